// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory request
// at a time, holds the returned word for decode and handles PC redirects,
// dropping any response made stale by a redirect.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  // REQ: request on the bus, WAIT: request accepted and response pending,
  // HOLD: instruction presented to decode, KILL: waiting to drop a stale response.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic            instr_valid_nxt;
  logic [31:0]     instruction_nxt;
  logic [XLEN-1:0] instr_pc_nxt;
  logic [XLEN-1:0] redirect_target;

  // The low two bits of a redirect target are forced to zero so fetches stay word aligned.
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // The request is only offered in REQ, and never while reset is held.
  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_req_addr  = pc;

  // Next-state and datapath decisions; a redirect overrides every other event.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_valid_nxt = instr_valid;
    instruction_nxt = instruction;
    instr_pc_nxt    = instr_pc;

    if (redirect_valid) begin
      pc_nxt          = redirect_target;
      instr_valid_nxt = 1'b0;
      case (state)
        REQ:     state_nxt = imem_req_ready  ? KILL : REQ;
        WAIT:    state_nxt = imem_resp_valid ? REQ  : KILL;
        HOLD:    state_nxt = REQ;
        KILL:    state_nxt = imem_resp_valid ? REQ  : KILL;
        default: state_nxt = REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_req_ready) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            instruction_nxt = imem_resp_data;
            instr_pc_nxt    = pc;
            instr_valid_nxt = 1'b1;
            pc_nxt          = pc + XLEN'(4);
            state_nxt       = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_nxt = 1'b0;
            state_nxt       = REQ;
          end
        end
        KILL: begin
          if (imem_resp_valid) begin
            state_nxt = REQ;
          end
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset to the boot PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_valid <= instr_valid_nxt;
      instruction <= instruction_nxt;
      instr_pc    <= instr_pc_nxt;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode controller.
- Owns the 64-bit PC and issues one word request at a time to instruction memory over a valid/ready handshake.
- Holds the returned 32-bit instruction stable for decode until decode accepts it.
- Supports a PC redirect from execute for branches and jumps, and discards any in-flight response made stale by the redirect.

Parameters:
- XLEN, 64, width of the PC and of instruction-memory addresses.
- RESET_PC, 64'h0, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_resp_valid  in  1  response data valid
- imem_resp_data  in  32  fetched instruction word
- instr_valid  out  1  instruction presented to decode
- instr_ready  in  1  decode consumes the instruction this cycle
- instruction  out  32  instruction word to decode
- instr_pc  out  XLEN  PC of the presented instruction
- redirect_valid  in  1  load a new PC
- redirect_pc  in  XLEN  new PC; bits [1:0] are ignored and treated as 0

Behaviour:
- State machine has four states: REQ, WAIT, HOLD, KILL. At most one request is outstanding.
- Reset, sampled on the clk edge while rst=1:
  - state=REQ, pc=RESET_PC
  - instr_valid=0, instruction=0, instr_pc=0
  - imem_req_valid=0 while rst is high; it rises combinationally in the first cycle after rst falls, with imem_req_addr=RESET_PC.
  - Reset mid-operation abandons any outstanding request. A response arriving after reset is ignored unless the block is in WAIT or KILL.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - imem_req_ready=1 -> WAIT.
  - Address stays stable while valid and not accepted; a redirect is the only exception.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: instruction<=imem_resp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0), then -> HOLD.
  - Memory never responds in the same cycle it accepts a request.
  - Minimum latency: request accepted in cycle N, response in N+1, instr_valid high in N+2.
- HOLD:
  - instr_valid, instruction and instr_pc are held stable until instr_ready=1.
  - On that handshake, instr_valid<=0 and -> REQ.
  - Sustained throughput is one instruction per 3 cycles with zero-wait memory.
- KILL:
  - Waits for the stale response and drops it: instruction and instr_pc are not updated.
  - imem_resp_valid -> REQ.
- imem_resp_valid in REQ or HOLD is ignored.
- Redirect has highest priority, in any state with rst=0:
  - pc<={redirect_pc[XLEN-1:2],2'b00} and instr_valid<=0.
  - WAIT -> KILL.
  - REQ with imem_req_ready=1 in the same cycle -> KILL, because the old-PC request was accepted.
  - REQ without imem_req_ready -> REQ; the address changes next cycle to the new pc.
  - HOLD -> REQ. The held instruction is discarded even if instr_ready=1 in the same cycle.
  - KILL -> KILL with the pc updated; still exactly one response is dropped.
  - WAIT with redirect and imem_resp_valid in the same cycle -> REQ, response dropped, since nothing remains outstanding.
- Arithmetic: the PC increment is a plain XLEN-bit add of 4, with no exception on overflow.

Test Plan:
- Reset with RESET_PC=64'h1000, always-ready memory returning 32'h00500093 one cycle after acceptance, instr_ready=1 -> first request addr 64'h1000 in cycle 1 after reset; instr_valid=1 with instruction=32'h00500093, instr_pc=64'h1000; next request addr 64'h1004.
- Backpressure: instr_ready=0 for 5 cycles -> instruction and instr_pc stable and no new imem_req_valid; instr_ready=1 -> next request issued at 64'h1004 in the following cycle.
- Memory stall: imem_req_ready=0 for 3 cycles -> imem_req_valid=1 with addr held at 64'h1004; accepted on the 4th cycle; response 2 cycles later is delivered correctly.
- Redirect in WAIT to 64'h2003 -> stale response dropped (instr_valid stays 0); next request addr 64'h2000; that response is presented with instr_pc=64'h2000.
- Simultaneous cases: redirect with imem_req_ready in REQ -> one response dropped. Redirect with imem_resp_valid in WAIT -> no drop, and the next request is at the redirect target. Redirect with instr_ready in HOLD -> instr_valid=0 next cycle.
- Wrap and reset: PC at 64'hFFFF_FFFF_FFFF_FFFC -> next fetch addr 0. rst asserted in WAIT -> instr_valid=0; first request after reset at RESET_PC; the late response is ignored.
